// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared types, constants and helpers for the MEM-stage
//             load/store engine (mem_access_unit, load_extend).
//  Revision : 1.0  initial release
// ============================================================================
package mem_pkg;

  localparam int BYTES_PER_WORD = 8;
  localparam int OFFSET_BITS    = 3;

  // Access size encoding, as delivered by the EX/MEM register
  typedef enum logic [1:0] {
    BYTE  = 2'd0,
    HALF  = 2'd1,
    WORD  = 2'd2,
    DWORD = 2'd3
  } mem_size_e;

  // Load/store engine states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } mau_state_e;

  // Offset bits that must be zero for a naturally aligned access of this size
  function automatic logic [OFFSET_BITS-1:0] size_low_mask(input mem_size_e size);
    logic [OFFSET_BITS-1:0] mask;
    case (size)
      BYTE:    mask = 3'b000;
      HALF:    mask = 3'b001;
      WORD:    mask = 3'b011;
      default: mask = 3'b111;
    endcase
    return mask;
  endfunction

  // Byte-lane enables: one bit per byte of the access, moved up to its offset.
  // Bits shifted beyond lane 7 are dropped.
  function automatic logic [BYTES_PER_WORD-1:0] byte_enables(
    input mem_size_e              size,
    input logic [OFFSET_BITS-1:0] offset
  );
    logic [BYTES_PER_WORD-1:0] base;
    case (size)
      BYTE:    base = 8'h01;
      HALF:    base = 8'h03;
      WORD:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
//  Module   : load_extend
//  Purpose  : Combinational load-data extraction: shifts the addressed bytes
//             of a memory word down to bit 0, then sign- or zero-extends the
//             byte/half/word result to the full data width.
//  Revision : 1.0  initial release
// ============================================================================
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]  rdata_i,
  input  logic [OFFSET_BITS-1:0] offset_i,
  input  mem_size_e              size_i,
  input  logic                   unsigned_i,
  output logic [DATA_WIDTH-1:0]  data_o
);

  logic [DATA_WIDTH-1:0] w_shifted;

  // Bring the addressed lane to bit 0, then replicate the sign (or zero) above it
  always_comb begin
    w_shifted = rdata_i >> {offset_i, 3'b000};
    data_o    = w_shifted;
    case (size_i)
      BYTE:    data_o = {{(DATA_WIDTH-8){~unsigned_i & w_shifted[7]}},   w_shifted[7:0]};
      HALF:    data_o = {{(DATA_WIDTH-16){~unsigned_i & w_shifted[15]}}, w_shifted[15:0]};
      WORD:    data_o = {{(DATA_WIDTH-32){~unsigned_i & w_shifted[31]}}, w_shifted[31:0]};
      default: data_o = w_shifted;
    endcase
  end

endmodule : load_extend
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : MEM-stage load/store engine. Issues one valid/ready request per
//             load or store, aligns store data to its byte lane, generates
//             byte enables, extends load data and stalls the pipeline until
//             the access completes.
//  Config   : MEM_MISALIGN_TRAP_EN - when defined, misaligned accesses skip
//             the memory request and raise misaligned_out for one cycle;
//             otherwise the offset is silently rounded down to alignment.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] wdata_in,
  input  logic [1:0]            size_in,
  input  logic                  unsigned_in,
  output logic                  dmem_req_valid,
  input  logic                  dmem_req_ready,
  output logic                  dmem_req_we,
  output logic [ADDR_WIDTH-1:0] dmem_req_addr,
  output logic [DATA_WIDTH-1:0] dmem_req_wdata,
  output logic [7:0]            dmem_req_be,
  input  logic                  dmem_resp_valid,
  input  logic [DATA_WIDTH-1:0] dmem_resp_rdata,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  load_valid_out,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic                  misaligned_out,
`endif
  output logic                  stall_out
);

  mau_state_e             state_q;
  logic                   req_valid_q;
  logic                   req_we_q;
  logic [ADDR_WIDTH-1:0]  req_addr_q;
  logic [DATA_WIDTH-1:0]  req_wdata_q;
  logic [7:0]             req_be_q;
  logic [OFFSET_BITS-1:0] offset_q;
  mem_size_e              size_q;
  logic                   unsigned_q;
  logic [DATA_WIDTH-1:0]  load_data_q;
  logic                   load_valid_q;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                   misaligned_q;
`endif

  logic                   access_w;
  mem_size_e              size_d;
  logic [OFFSET_BITS-1:0] offset_d;
  logic                   trap_d;
  logic [7:0]             be_d;
  logic [DATA_WIDTH-1:0]  wdata_d;
  logic [ADDR_WIDTH-1:0]  addr_d;
  logic [DATA_WIDTH-1:0]  ext_data_w;

  assign access_w = mem_read_in | mem_write_in;
  assign size_d   = mem_size_e'(size_in);

  // Request fields derived from the EX/MEM inputs, captured on entry to REQ
  always_comb begin
    offset_d = addr_in[OFFSET_BITS-1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    trap_d   = |(offset_d & size_low_mask(size_d));
`else
    trap_d   = 1'b0;
    offset_d = offset_d & ~size_low_mask(size_d);
`endif
    be_d    = byte_enables(size_d, offset_d);
    wdata_d = wdata_in << {offset_d, 3'b000};
    addr_d  = {addr_in[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  end

  // Response extraction uses the captured offset/size so the inputs may move
  load_extend #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_extend (
    .rdata_i    (dmem_resp_rdata),
    .offset_i   (offset_q),
    .size_i     (size_q),
    .unsigned_i (unsigned_q),
    .data_o     (ext_data_w)
  );

  // Access sequencer: IDLE -> REQ -> (WAIT_RESP for loads) -> DONE -> IDLE
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      req_valid_q  <= 1'b0;
      req_we_q     <= 1'b0;
      req_addr_q   <= '0;
      req_wdata_q  <= '0;
      req_be_q     <= '0;
      offset_q     <= '0;
      size_q       <= BYTE;
      unsigned_q   <= 1'b0;
      load_data_q  <= '0;
      load_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
    end else begin
      // Single-cycle pulses default low
      load_valid_q <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (access_w) begin
            if (trap_d) begin
`ifdef MEM_MISALIGN_TRAP_EN
              misaligned_q <= 1'b1;
`endif
              state_q <= DONE;
            end else begin
              // A simultaneous read and write is treated as a store
              req_valid_q <= 1'b1;
              req_we_q    <= mem_write_in;
              req_addr_q  <= addr_d;
              req_wdata_q <= wdata_d;
              req_be_q    <= be_d;
              offset_q    <= offset_d;
              size_q      <= size_d;
              unsigned_q  <= unsigned_in;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= req_we_q ? DONE : WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (dmem_resp_valid) begin
            load_data_q  <= ext_data_w;
            load_valid_q <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Hold upstream while an access is being started or is outstanding
  assign stall_out = ~reset &
                     (((state_q == IDLE) & access_w) |
                      (state_q == REQ) |
                      (state_q == WAIT_RESP));

  assign dmem_req_valid = req_valid_q;
  assign dmem_req_we    = req_we_q;
  assign dmem_req_addr  = req_addr_q;
  assign dmem_req_wdata = req_wdata_q;
  assign dmem_req_be    = req_be_q;
  assign load_data_out  = load_data_q;
  assign load_valid_out = load_valid_q;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned_out = misaligned_q;
`endif

endmodule : mem_access_unit
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Self-checking bench for mem_access_unit: directed scenarios
//             followed by randomized loads/stores against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        mem_read_in;
  logic        mem_write_in;
  logic [63:0] addr_in;
  logic [63:0] wdata_in;
  logic [1:0]  size_in;
  logic        unsigned_in;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_req_we;
  logic [63:0] dmem_req_addr;
  logic [63:0] dmem_req_wdata;
  logic [7:0]  dmem_req_be;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_rdata;
  logic [63:0] load_data_out;
  logic        load_valid_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned_out;
`endif
  logic        stall_out;

  int          n_chk = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  logic [63:0] exp_load = '0;

  mem_access_unit #(
    .ADDR_WIDTH (64),
    .DATA_WIDTH (64)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_read_in     (mem_read_in),
    .mem_write_in    (mem_write_in),
    .addr_in         (addr_in),
    .wdata_in        (wdata_in),
    .size_in         (size_in),
    .unsigned_in     (unsigned_in),
    .dmem_req_valid  (dmem_req_valid),
    .dmem_req_ready  (dmem_req_ready),
    .dmem_req_we     (dmem_req_we),
    .dmem_req_addr   (dmem_req_addr),
    .dmem_req_wdata  (dmem_req_wdata),
    .dmem_req_be     (dmem_req_be),
    .dmem_resp_valid (dmem_resp_valid),
    .dmem_resp_rdata (dmem_resp_rdata),
    .load_data_out   (load_data_out),
    .load_valid_out  (load_valid_out),
`ifdef MEM_MISALIGN_TRAP_EN
    .misaligned_out  (misaligned_out),
`endif
    .stall_out       (stall_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count every request handshake seen on the memory port
  always @(posedge clk) begin
    if (dmem_req_valid && dmem_req_ready) hs_cnt++;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp);
    end
  endtask

  // Reference: byte enables from byte count and offset
  function automatic logic [7:0] model_be(input int nb, input int o);
    int m;
    m = ((1 << nb) - 1) << o;
    return 8'(m & 255);
  endfunction

  // Reference: extract nb bytes at offset o, extend to 64 bits
  function automatic logic [63:0] model_load(input logic [63:0] rd, input int o,
                                             input int nb, input logic uns);
    logic [63:0] v;
    logic [63:0] mask;
    v    = rd >> (8 * o);
    mask = (nb == 8) ? {64{1'b1}} : ((64'd1 << (8 * nb)) - 64'd1);
    v    = v & mask;
    if (!uns && nb < 8 && v[8*nb-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_inputs();
    mem_read_in  = 1'b0;
    mem_write_in = 1'b0;
    addr_in      = '0;
    wdata_in     = '0;
    size_in      = '0;
    unsigned_in  = 1'b0;
  endtask

  // One complete access, starting with the DUT idle at posedge+1
  task automatic run_access(input logic wr, input logic rd, input logic [63:0] a,
                            input logic [63:0] wd, input logic [1:0] sz, input logic uns,
                            input int rdly, input int pdly, input logic [63:0] rdata);
    int          nb;
    int          o;
    logic        trap;
    logic [63:0] e_addr;
    logic [63:0] e_wd;
    logic [7:0]  e_be;
    logic [63:0] e_ld;
    int          hs0;
    int          waited;
    logic        done;

    nb   = 1 << sz;
    o    = int'(a[2:0]);
    trap = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
    trap = (o % nb) != 0;
`else
    o = o - (o % nb);
`endif
    e_addr = a & ~64'h7;
    e_wd   = wd << (8 * o);
    e_be   = model_be(nb, o);
    e_ld   = model_load(rdata, o, nb, uns);
    hs0    = hs_cnt;

    mem_write_in = wr;
    mem_read_in  = rd;
    addr_in      = a;
    wdata_in     = wd;
    size_in      = sz;
    unsigned_in  = uns;
    #1;
    check_eq("idle_stall", 64'(stall_out), 64'd1);
    check_eq("idle_valid", 64'(dmem_req_valid), 64'd0);
    @(posedge clk);
    #1;

    if (trap) begin
`ifdef MEM_MISALIGN_TRAP_EN
      check_eq("trap_flag", 64'(misaligned_out), 64'd1);
`endif
      check_eq("trap_valid", 64'(dmem_req_valid), 64'd0);
      check_eq("trap_lvalid", 64'(load_valid_out), 64'd0);
      check_eq("trap_stall", 64'(stall_out), 64'd0);
      drop_inputs();
      tick();
`ifdef MEM_MISALIGN_TRAP_EN
      check_eq("trap_flag_clr", 64'(misaligned_out), 64'd0);
`endif
      check_eq("trap_hs", 64'(hs_cnt - hs0), 64'd0);
      return;
    end

    // Request phase: fields must stay put until the handshake
    waited = 0;
    done   = 1'b0;
    while (!done) begin
      check_eq("req_valid", 64'(dmem_req_valid), 64'd1);
      check_eq("req_we", 64'(dmem_req_we), 64'(wr));
      check_eq("req_addr", dmem_req_addr, e_addr);
      check_eq("req_be", 64'(dmem_req_be), 64'(e_be));
      check_eq("req_wdata", dmem_req_wdata, e_wd);
      check_eq("req_stall", 64'(stall_out), 64'd1);
      dmem_req_ready  = (waited >= rdly);
      dmem_resp_valid = 1'($urandom % 2);
      dmem_resp_rdata = {$urandom, $urandom};
      @(posedge clk);
      #1;
      if (dmem_req_ready) done = 1'b1;
      waited++;
    end
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    check_eq("post_hs_valid", 64'(dmem_req_valid), 64'd0);

    if (!wr) begin
      waited = 0;
      done   = 1'b0;
      while (!done) begin
        check_eq("wait_stall", 64'(stall_out), 64'd1);
        check_eq("wait_lvalid", 64'(load_valid_out), 64'd0);
        dmem_resp_valid = (waited >= pdly);
        dmem_resp_rdata = dmem_resp_valid ? rdata : {$urandom, $urandom};
        @(posedge clk);
        #1;
        if (dmem_resp_valid) done = 1'b1;
        waited++;
      end
      dmem_resp_valid = 1'b0;
      exp_load = e_ld;
      check_eq("done_lvalid", 64'(load_valid_out), 64'd1);
      check_eq("done_ldata", load_data_out, exp_load);
    end else begin
      check_eq("done_lvalid_st", 64'(load_valid_out), 64'd0);
      check_eq("done_ldata_hold", load_data_out, exp_load);
    end
    check_eq("done_stall", 64'(stall_out), 64'd0);

    drop_inputs();
    tick();
    check_eq("after_lvalid", 64'(load_valid_out), 64'd0);
    check_eq("after_stall", 64'(stall_out), 64'd0);
    check_eq("after_ldata", load_data_out, exp_load);
    check_eq("hs_count", 64'(hs_cnt - hs0), 64'd1);
  endtask

  // Reset while a load waits for its response; the late response is dropped
  task automatic reset_in_wait();
    mem_read_in = 1'b1;
    addr_in     = 64'h5008;
    size_in     = 2'd2;
    tick();
    dmem_req_ready = 1'b1;
    tick();
    dmem_req_ready = 1'b0;
    check_eq("rst_wait_stall", 64'(stall_out), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drop_inputs();
    #1;
    check_eq("rst_valid", 64'(dmem_req_valid), 64'd0);
    check_eq("rst_we", 64'(dmem_req_we), 64'd0);
    check_eq("rst_addr", dmem_req_addr, 64'd0);
    check_eq("rst_be", 64'(dmem_req_be), 64'd0);
    check_eq("rst_ldata", load_data_out, 64'd0);
    check_eq("rst_stall", 64'(stall_out), 64'd0);
    exp_load = '0;
    dmem_resp_valid = 1'b1;
    dmem_resp_rdata = 64'hDEADBEEFCAFEF00D;
    tick();
    dmem_resp_valid = 1'b0;
    check_eq("rst_ign_lvalid", 64'(load_valid_out), 64'd0);
    check_eq("rst_ign_ldata", load_data_out, 64'd0);
    check_eq("rst_ign_stall", 64'(stall_out), 64'd0);
  endtask

  initial begin
    logic        wr;
    logic        rd;
    logic [63:0] a;
    logic [1:0]  sz;
    int          kind;

    reset           = 1'b1;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_rdata = '0;
    drop_inputs();
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_valid", 64'(dmem_req_valid), 64'd0);
    check_eq("reset_we", 64'(dmem_req_we), 64'd0);
    check_eq("reset_addr", dmem_req_addr, 64'd0);
    check_eq("reset_wdata", dmem_req_wdata, 64'd0);
    check_eq("reset_be", 64'(dmem_req_be), 64'd0);
    check_eq("reset_ldata", load_data_out, 64'd0);
    check_eq("reset_lvalid", 64'(load_valid_out), 64'd0);
    check_eq("reset_stall", 64'(stall_out), 64'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check_eq("reset_misal", 64'(misaligned_out), 64'd0);
`endif
    reset = 1'b0;
    tick();

    run_access(1'b1, 1'b0, 64'h1000, 64'h1122334455667788, 2'd3, 1'b0, 0, 0, 64'd0);
    run_access(1'b1, 1'b0, 64'h1005, 64'h00000000000000AB, 2'd0, 1'b0, 0, 0, 64'd0);
    run_access(1'b0, 1'b1, 64'h2003, 64'd0, 2'd0, 1'b0, 0, 0, 64'h00000000F0000000);
    run_access(1'b0, 1'b1, 64'h2003, 64'd0, 2'd0, 1'b1, 0, 0, 64'h00000000F0000000);
    run_access(1'b0, 1'b1, 64'h4014, 64'h5555, 2'd2, 1'b0, 5, 3, 64'h89ABCDEF01234567);
    run_access(1'b1, 1'b1, 64'h4006, 64'hBEEF, 2'd1, 1'b0, 2, 0, 64'd0);
    reset_in_wait();
    run_access(1'b0, 1'b1, 64'h3001, 64'd0, 2'd1, 1'b0, 0, 0, 64'h000000000000C0DE);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom % 4);
      wr   = (kind == 1) || (kind == 2);
      rd   = (kind != 1);
      sz   = 2'($urandom % 4);
      a    = {$urandom, $urandom};
      if (($urandom % 4) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      run_access(wr, rd, a, {$urandom, $urandom}, sz, 1'($urandom % 2),
                 int'($urandom % 4), int'($urandom % 4), {$urandom, $urandom});
      repeat ($urandom % 3) begin
        tick();
        check_eq("gap_stall", 64'(stall_out), 64'd0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_mem_access_unit
`default_nettype wire

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage load/store engine. It sits directly downstream of the EX/MEM pipeline register and consumes its registered mem_read/mem_write controls, address and store data. It drives a valid/ready data-memory request port, aligns store data and generates byte enables, then extracts and extends load data. It holds the pipeline with stall_out until the access completes.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 64, memory data bus width; fixed 8 bytes, so offset = addr[2:0]

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
mem_read_in  input  1  load requested (from EX/MEM register)
mem_write_in  input  1  store requested (from EX/MEM register)
addr_in  input  ADDR_WIDTH  effective byte address
wdata_in  input  DATA_WIDTH  store data, right-justified
size_in  input  2  0=byte, 1=half, 2=word, 3=dword
unsigned_in  input  1  zero-extend loads when 1
dmem_req_valid  output  1  request valid
dmem_req_ready  input  1  memory accepts request
dmem_req_we  output  1  1=store, 0=load
dmem_req_addr  output  ADDR_WIDTH  8-byte-aligned address (addr[2:0] cleared)
dmem_req_wdata  output  DATA_WIDTH  store data shifted to lane
dmem_req_be  output  8  byte enables
dmem_resp_valid  input  1  load response valid
dmem_resp_rdata  input  DATA_WIDTH  load response data
load_data_out  output  DATA_WIDTH  extended load result
load_valid_out  output  1  load_data_out valid this cycle
stall_out  output  1  hold upstream pipeline registers

Behaviour:
- Clock is clk; reset is synchronous and active-high.
- Reset: state=IDLE. All outputs are 0: dmem_req_valid, dmem_req_we, dmem_req_addr, dmem_req_wdata, dmem_req_be, load_data_out, load_valid_out and stall_out.
- Reset mid-operation returns to IDLE on the next edge. Any in-flight response is ignored.
- stall_out is combinational and equals 1 when:
  - in IDLE with (mem_read_in | mem_write_in), or
  - in REQ, or
  - in WAIT_RESP.
- stall_out is 0 in DONE and in IDLE with no access.
- FSM:
  - IDLE: on an access, capture we, aligned address, shifted wdata, BE, offset, size and unsigned, then go to REQ. If both mem_read_in and mem_write_in are 1, the store wins.
  - REQ: dmem_req_valid=1 with stable fields until dmem_req_ready. On handshake, a store goes to DONE and a load goes to WAIT_RESP.
  - WAIT_RESP: on dmem_resp_valid, register the extended data and go to DONE. A response arriving in any other state is ignored.
  - DONE: exactly one cycle. load_valid_out=1 only for loads. Then IDLE. The pipeline advances at the end of DONE, so the same instruction is never re-issued.
- Minimum latency, load with ready and resp each arriving in the first possible cycle: 4 cycles (IDLE, REQ, WAIT_RESP, DONE). A store with immediate ready takes 3 cycles.
- BE = ((1 << (1 << size)) - 1) << offset, truncated to 8 bits.
- wdata lane: dmem_req_wdata = wdata_in << (offset*8).
- Load extraction: shift rdata right by offset*8. Take the low 8/16/32/64 bits. Sign-extend from the top bit unless unsigned_in; size 3 has no extension.
- load_data_out holds its last value until the next load completes. load_valid_out is a 1-cycle pulse.

Optional Feature:
Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output misaligned_out (1 bit, reset 0).
  - In IDLE, an access with offset not a multiple of (1 << size) issues no request and goes directly to DONE.
  - In that DONE cycle: misaligned_out=1, load_valid_out=0.
- Undefined:
  - No port.
  - offset is forced to an aligned value by clearing its low size bits before use.

Decomposition:
- Shared package mem_pkg:
  - mem_size_e (BYTE, HALF, WORD, DWORD)
  - mau_state_e (IDLE, REQ, WAIT_RESP, DONE)
  - constants BYTES_PER_WORD=8 and OFFSET_BITS=3
- One sub-module, load_extend: a combinational shift plus sign/zero extend from (rdata, offset, size, unsigned) to DATA_WIDTH. It is instantiated once and unit-tested separately.

Test Plan:
1. Store dword: addr 0x1000, wdata 0x1122334455667788, ready tied 1 -> req_addr 0x1000, be 0xFF, stall high 2 cycles, done in cycle 3.
2. Store byte: addr 0x1005, wdata 0xAB -> req_addr 0x1000, be 0x20, wdata lane 0x0000AB0000000000.
3. Load signed byte at 0x2003, rdata 0x00000000F0000000 -> load_data_out 0xFFFFFFFFFFFFFFF0. With unsigned_in=1 -> 0x00000000000000F0. load_valid_out pulses once.
4. Backpressure: ready low 5 cycles, then resp delayed 3 -> req fields stable throughout, stall_out held, single request handshake.
5. Reset asserted in WAIT_RESP, then resp_valid arrives -> IDLE next cycle, all outputs 0, response ignored.
6. With MEM_MISALIGN_TRAP_EN: half load at 0x3001 -> no dmem_req_valid, misaligned_out=1 for exactly one cycle.
